axil_master_seq: RTL and testbench

AXIL_MASTER_SEQ -- requirements
Module: axil_master_seq

---
 rtl/axil_master_seq.sv | 179 +++++++++++++++++
 tb/tb_axil_master_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_seq.sv
// rtl/axil_master_seq.sv - single-outstanding AXI4-Lite master sequencer with per-transaction timeout
module axil_master_seq #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [15:0] txn_count
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] tmo_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        tmo_hit;
    logic        aw_done;
    logic        w_done;
    logic        busy;
    logic        ld_wr;
    logic        ld_rd;
    logic        ld_tmo;

    assign accept  = cmd_valid && cmd_ready;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign aw_done = !m_awvalid || m_awready;
    assign w_done  = !m_wvalid || m_wready;
    assign busy    = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = 4'hF;

    // Completion handshakes are checked before the timeout so they win on the threshold cycle
    always_comb begin
        state_next = state;
        ld_wr      = 1'b0;
        ld_rd      = 1'b0;
        ld_tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = cmd_wr ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                if (tmo_hit) begin
                    state_next = RSP;
                    ld_tmo     = 1'b1;
                end else if (aw_done && w_done) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid && m_bready) begin
                    state_next = RSP;
                    ld_wr      = 1'b1;
                end else if (tmo_hit) begin
                    state_next = RSP;
                    ld_tmo     = 1'b1;
                end
            end
            RD_REQ: begin
                if (tmo_hit) begin
                    state_next = RSP;
                    ld_tmo     = 1'b1;
                end else if (m_arvalid && m_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid && m_rready) begin
                    state_next = RSP;
                    ld_rd      = 1'b1;
                end else if (tmo_hit) begin
                    state_next = RSP;
                    ld_tmo     = 1'b1;
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Handshake outputs are registered from the next state so none depends combinationally on an input
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
            txn_count   <= '0;
            tmo_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RSP);
            m_awvalid <= (state_next == WR_REQ) && ((state == IDLE) || (m_awvalid && !m_awready));
            m_wvalid  <= (state_next == WR_REQ) && ((state == IDLE) || (m_wvalid && !m_wready));
            m_bready  <= (state_next == WR_RESP);
            m_arvalid <= (state_next == RD_REQ);
            m_rready  <= (state_next == RD_DATA);

            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                tmo_cnt <= '0;
            end else if (busy) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (ld_wr) begin
                rsp_rdata   <= '0;
                rsp_resp    <= m_bresp;
                rsp_timeout <= 1'b0;
            end else if (ld_rd) begin
                rsp_rdata   <= m_rdata;
                rsp_resp    <= m_rresp;
                rsp_timeout <= 1'b0;
            end else if (ld_tmo) begin
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
            end

            if (ld_wr || ld_rd || ld_tmo) txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axil_master_seq.sv
// tb/tb_axil_master_seq.sv - directed and randomized bench for axil_master_seq with a cycle-count outcome model
module tb_axil_master_seq;

    localparam int T     = 16;
    localparam int NEVER = 100000;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [15:0] txn_count;

    always #5 axi_clk = ~axi_clk;

    axil_master_seq #(.TIMEOUT_CYCLES(T)) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .txn_count(txn_count)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_count;

    int          aw_d, w_d, b_d, ar_d, r_d;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic        cur_wr;
    logic [31:0] cur_addr, cur_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_awvalid"}, m_awvalid, 0);
        chk({tag, "_wvalid"}, m_wvalid, 0);
        chk({tag, "_arvalid"}, m_arvalid, 0);
        chk({tag, "_bready"}, m_bready, 0);
        chk({tag, "_rready"}, m_rready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_resp"}, rsp_resp, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_txn_count"}, txn_count, 0);
        chk({tag, "_awaddr"}, m_awaddr, 0);
        chk({tag, "_wdata"}, m_wdata, 0);
    endtask

    task automatic slave_idle();
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_rvalid = 0;
    endtask

    // One slave cycle, executed at a negedge: check master state, then drive this cycle's responses
    task automatic slave_step();
        if (cur_wr) begin
            chk("awvalid_hold", m_awvalid, aw_hs == 0);
            chk("wvalid_hold", m_wvalid, w_hs == 0);
            chk("bready", m_bready, (aw_hs > 0) && (w_hs > 0));
            chk("arvalid_quiet", m_arvalid, 0);
        end else begin
            chk("arvalid_hold", m_arvalid, ar_hs == 0);
            chk("rready", m_rready, ar_hs > 0);
            chk("awvalid_quiet", m_awvalid, 0);
        end
        chk("cmd_ready_busy", cmd_ready, 0);

        if (b_hs > 0) m_bvalid = 0;
        else if (cur_wr && aw_hs > 0 && w_hs > 0) begin
            if (b_wait >= b_d) begin m_bvalid = 1; m_bresp = s_resp; end
            b_wait++;
        end
        if (r_hs > 0) m_rvalid = 0;
        else if (!cur_wr && ar_hs > 0) begin
            if (r_wait >= r_d) begin m_rvalid = 1; m_rdata = s_rdata; m_rresp = s_resp; end
            r_wait++;
        end

        m_awready = m_awvalid && (aw_wait >= aw_d);
        if (m_awvalid) aw_wait++;
        m_wready = m_wvalid && (w_wait >= w_d);
        if (m_wvalid) w_wait++;
        m_arready = m_arvalid && (ar_wait >= ar_d);
        if (m_arvalid) ar_wait++;

        if (m_awvalid && m_awready) begin
            aw_hs++;
            chk("awaddr", m_awaddr, cur_addr);
            chk("awprot", m_awprot, 0);
        end
        if (m_wvalid && m_wready) begin
            w_hs++;
            chk("wdata", m_wdata, cur_wdata);
            chk("wstrb", m_wstrb, 4'hF);
        end
        if (m_arvalid && m_arready) begin
            ar_hs++;
            chk("araddr", m_araddr, cur_addr);
            chk("arprot", m_arprot, 0);
        end
        if (m_bvalid && m_bready) b_hs++;
        if (m_rvalid && m_rready) r_hs++;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r,
                           input logic [1:0] resp, input logic [31:0] rdata,
                           input int hold, input logic junk, input int rst_at);
        int          k;
        int          c_done;
        logic        tmo;
        logic        was_rst;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        cur_wr = wr; cur_addr = addr; cur_wdata = wdata;
        aw_d = d_aw; w_d = d_w; b_d = d_b; ar_d = d_ar; r_d = d_r;
        s_resp = resp; s_rdata = rdata;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        slave_idle();
        @(negedge axi_clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge axi_clk);
        cmd_valid = junk; cmd_wr = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        k = 1;
        was_rst = 0;
        while (!rsp_valid && k <= 200) begin
            if (k == rst_at) begin
                was_rst = 1;
                break;
            end
            slave_step();
            @(negedge axi_clk);
            k++;
        end
        cmd_valid = 0;
        slave_idle();
        if (was_rst) begin
            #2 axi_rst = 1;
            #1 chk_reset("midrst");
            @(negedge axi_clk);
            axi_rst = 0;
            exp_count = 0;
        end else begin
            // A transaction completes c_done cycles after acceptance; beyond T cycles it is aborted
            c_done = wr ? ((d_aw > d_w ? d_aw : d_w) + 2 + d_b) : (d_ar + 2 + d_r);
            tmo = (c_done > T);
            exp_count = exp_count + 16'd1;
            if (tmo) begin e_rdata = 0; e_resp = 2'b10; end
            else if (wr) begin e_rdata = 0; e_resp = resp; end
            else begin e_rdata = rdata; e_resp = resp; end
            chk("rsp_latency", k, tmo ? T + 1 : c_done + 1);
            chk("rsp_awvalid", m_awvalid, 0);
            chk("rsp_wvalid", m_wvalid, 0);
            chk("rsp_arvalid", m_arvalid, 0);
            chk("rsp_bready", m_bready, 0);
            chk("rsp_rready", m_rready, 0);
            if (!tmo) begin
                chk("aw_hs_count", aw_hs, wr ? 1 : 0);
                chk("w_hs_count", w_hs, wr ? 1 : 0);
                chk("ar_hs_count", ar_hs, wr ? 0 : 1);
            end
            for (int i = 0; i <= hold; i++) begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_resp", rsp_resp, e_resp);
                chk("rsp_timeout", rsp_timeout, tmo);
                chk("txn_count", txn_count, exp_count);
                chk("cmd_ready_rsp", cmd_ready, 0);
                if (i == hold) rsp_ready = 1;
                @(negedge axi_clk);
            end
            rsp_ready = 0;
            chk("rsp_valid_after", rsp_valid, 0);
            chk("cmd_ready_after", cmd_ready, 1);
        end
    endtask

    initial begin
        logic        r_wr;
        logic [31:0] r_addr, r_wdata, r_rdata;
        logic [1:0]  r_resp;
        int          r_aw, r_w, r_b, r_ar, r_rd, r_hold;
        axi_rst = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; m_bresp = 0; m_rdata = 0; m_rresp = 0;
        slave_idle();
        exp_count = 0;
        repeat (3) @(negedge axi_clk);
        chk_reset("reset");
        chk("reset_wstrb", m_wstrb, 4'hF);
        axi_rst = 0;

        run_txn(1, 32'h0000_0004, 32'hA5A5_1234, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        run_txn(0, 32'h0000_0020, 0, 0, 0, 0, 0, 3, 2'b00, 32'hDEAD_BEEF, 0, 0, 0);
        run_txn(1, 32'h0000_0100, 32'h1357_9BDF, 5, 0, 2, 0, 0, 2'b01, 0, 1, 1, 0);
        run_txn(0, 32'h0000_0040, 0, 0, 0, 0, NEVER, 0, 2'b00, 32'h1111_2222, 0, 0, 0);
        run_txn(1, 32'h0000_0044, 32'h0000_0055, 0, 0, NEVER, 0, 0, 2'b00, 0, 1, 0, 0);
        run_txn(0, 32'h0000_0048, 0, 0, 0, 0, 4, T - 6, 2'b11, 32'hCAFE_F00D, 0, 0, 0);
        run_txn(0, 32'h0000_004C, 0, 0, 0, 0, 4, T - 5, 2'b00, 32'h0F0F_0F0F, 0, 0, 0);
        run_txn(1, 32'h0000_0050, 32'h2468_ACE0, 3, 7, T - 9, 0, 0, 2'b10, 0, 0, 0, 0);
        run_txn(0, 32'h0000_0080, 0, 0, 0, 0, 1, 1, 2'b00, 32'h0BAD_CAFE, 10, 1, 0);
        run_txn(1, 32'h0000_00C0, 32'h0000_0077, 0, 0, NEVER, 0, 0, 2'b00, 0, 0, 0, 3);
        run_txn(1, 32'h0000_00C4, 32'h0000_0088, 1, 2, 1, 0, 0, 2'b10, 0, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_addr = $urandom; r_wdata = $urandom; r_rdata = $urandom;
            r_resp = 2'($urandom_range(0, 3));
            r_aw = $urandom_range(0, 8); r_w = $urandom_range(0, 8); r_b = $urandom_range(0, 8);
            r_ar = $urandom_range(0, 8); r_rd = $urandom_range(0, 8);
            r_hold = $urandom_range(0, 3);
            run_txn(r_wr, r_addr, r_wdata, r_aw, r_w, r_b, r_ar, r_rd, r_resp, r_rdata,
                    r_hold, 1'($urandom_range(0, 1)), 0);
        end

        @(negedge axi_clk);
        force dut.txn_count = 16'hFFFE;
        @(negedge axi_clk);
        release dut.txn_count;
        exp_count = 16'hFFFE;
        #1 chk("preload", txn_count, 16'hFFFE);
        run_txn(0, 32'h0000_0200, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0000_0001, 0, 0, 0);
        run_txn(1, 32'h0000_0204, 32'h0000_0002, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        run_txn(0, 32'h0000_0208, 0, 0, 0, 0, 0, 0, 2'b01, 32'h0000_0003, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
